fir_coef_bank_ctrl: RTL and testbench
=====================================

FIR_COEF_BANK_CTRL -- requirements
Module: fir_coef_bank_ctrl

Interface
REQ-001 Parameter N_TAPS, default 16, number of FIR coefficients; SHALL be even and ≥4.
REQ-002 Parameter COEF_W, default 12, coefficient width, two's complement.
REQ-003 Parameter SWAP_ON_TICK, default 1: 1 means the bank swap waits for sample_tick_i, 0 means the swap happens immediately.
REQ-004 Port clk_100MHz_i, input, 1 bit: the single clock; all logic SHALL run on its rising edge.
REQ-005 Port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port load_start_i, input, 1 bit: push-button level, asynchronous to the clock; its rising edge starts a load.
REQ-007 Port coef_i, input, COEF_W bits: coefficient value; SHALL be held stable while coef_strobe_i is high.
REQ-008 Port coef_strobe_i, input, 1 bit: level strobe, asynchronous to the clock; its rising edge writes one coefficient.
REQ-009 Port sym_i, input, 1 bit: symmetric mode; sampled only on the start edge.
REQ-010 Port sample_tick_i, input, 1 bit: one-cycle pulse marking the FIR sample boundary.
REQ-011 Port coefs_o, output, N_TAPS*COEF_W bits: active bank, with tap k at bits [k*COEF_W +: COEF_W].
REQ-012 Port loading_o, output, 1 bit: high in the LOAD and WAIT_SWAP states.
REQ-013 Port load_done_o, output, 1 bit: one-cycle pulse when a swap completes.
REQ-014 Port bank_sel_o, output, 1 bit: index of the active bank.
REQ-015 Port coef_cnt_o, output, $clog2(N_TAPS+1) bits: number of coefficients written in the current load.
REQ-016 Port err_o, output, 1 bit: sticky protocol error flag.

Function
REQ-017 Synchronisation: load_start_i and coef_strobe_i SHALL each pass through a 2-flop synchroniser followed by a rising-edge detector.
REQ-018 Edge latency: an edge pulse SHALL be asserted in the cycle after the 2nd clock edge at which the input is sampled high, and the action SHALL occur on the 3rd clock edge.
REQ-019 Storage: two banks of N_TAPS×COEF_W; coefs_o SHALL always drive bank[bank_sel_o]; writes SHALL go only to bank[~bank_sel_o].
REQ-020 State machine: IDLE, LOAD, WAIT_SWAP.
REQ-021 IDLE: a start edge SHALL latch sym_i, clear coef_cnt_o, clear err_o, and move to LOAD.
REQ-022 LOAD: each strobe edge SHALL write coef_i to shadow[idx] with idx = coef_cnt_o, then increment coef_cnt_o.
REQ-023 LOAD, symmetric mode: each strobe edge SHALL also write coef_i to shadow[N_TAPS-1-idx] in the same cycle.
REQ-024 LOAD exit: when coef_cnt_o reaches its target (N_TAPS, or N_TAPS/2 in symmetric mode), the block SHALL move to WAIT_SWAP on the same edge as the final write.
REQ-025 WAIT_SWAP with SWAP_ON_TICK=1: on the first sample_tick_i seen in this state, bank_sel_o SHALL toggle, load_done_o SHALL pulse for one cycle, and the block SHALL return to IDLE.
REQ-026 WAIT_SWAP with SWAP_ON_TICK=0: the swap SHALL occur on the clock edge after entry, regardless of sample_tick_i.
REQ-027 A sample_tick_i in the same cycle as the final write SHALL NOT swap; only ticks seen in WAIT_SWAP count.
REQ-028 A start edge in LOAD or WAIT_SWAP SHALL abort and restart: coef_cnt_o set to 0, state LOAD, no swap, err_o set.
REQ-029 A start edge and a strobe edge in the same cycle: the start SHALL win and the strobe SHALL be discarded.
REQ-030 A strobe edge in IDLE or WAIT_SWAP SHALL write nothing, SHALL set err_o, and the state SHALL be unchanged.
REQ-031 coef_cnt_o SHALL hold its final value until the next start edge, and SHALL never exceed its target.
REQ-032 Coefficients SHALL be stored bit-exact, with no sign extension or scaling.

Reset
REQ-033 While rst_i is high, the block SHALL immediately force: state IDLE, both banks all-zero, bank_sel_o=0, coef_cnt_o=0, loading_o=0, load_done_o=0, err_o=0, synchroniser and edge flops 0.
REQ-034 Reset during LOAD or WAIT_SWAP SHALL discard the partial load; coefs_o SHALL be all-zero after reset.
REQ-035 An input held high across reset release SHALL NOT generate an edge.

Verification
REQ-036 Full load: sym=0, start edge, then 16 strobe edges with -99, 65, 136, 33, -156, -86, 376, 854, 854, 376, -86, -156, 33, 136, 65, -99, then a tick. Required: tap0=0xF9D, tap7=0x356, tap15=0xF9D, bank_sel_o=1, one load_done_o pulse.
REQ-037 Symmetric load: sym=1, 8 strobe edges with -99 … 854, then a tick. Required: coefs_o identical to REQ-036, coef_cnt_o=8, err_o=0.
REQ-038 Swap hold-off: complete a load, then hold sample_tick_i low for 100 cycles. Required: bank_sel_o and coefs_o unchanged, loading_o=1; first tick causes the swap one edge later.
REQ-039 Abort: new start edge after 5 strobe edges. Required: coef_cnt_o=0, err_o=1, active bank unchanged; a full 16-coefficient reload then swaps correctly.
REQ-040 Stray strobe: strobe edge in IDLE. Required: err_o=1, no bank change. Also: start and strobe edges in the same cycle leave coef_cnt_o=0.
REQ-041 Reset mid-load: assert rst_i after 10 strobe edges. Required: all outputs take their reset values immediately; strobe still high at release produces no write.

Source files
------------

// File: rtl/fir_coef_bank_ctrl.sv
// fir_coef_bank_ctrl: double-buffered FIR coefficient bank with button-driven loading and sample-aligned swap
module fir_coef_bank_ctrl #(
  parameter int N_TAPS = 16,
  parameter int COEF_W = 12,
  parameter bit SWAP_ON_TICK = 1
) (
  input  logic                       clk_100MHz_i,
  input  logic                       rst_i,
  input  logic                       load_start_i,
  input  logic [COEF_W-1:0]          coef_i,
  input  logic                       coef_strobe_i,
  input  logic                       sym_i,
  input  logic                       sample_tick_i,
  output logic [N_TAPS*COEF_W-1:0]   coefs_o,
  output logic                       loading_o,
  output logic                       load_done_o,
  output logic                       bank_sel_o,
  output logic [$clog2(N_TAPS+1)-1:0] coef_cnt_o,
  output logic                       err_o
);
  localparam int CW = $clog2(N_TAPS + 1);
  localparam int IW = $clog2(N_TAPS);
  localparam logic [CW-1:0] FULL = CW'(N_TAPS);
  localparam logic [CW-1:0] HALF = CW'(N_TAPS / 2);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;
  state_t st, st_n;
  logic [COEF_W-1:0] bank [2][N_TAPS];
  logic start_s1, start_s2, start_d, start_arm;
  logic strb_s1, strb_s2, strb_d, strb_arm;
  logic [1:0] rdy;
  logic sym, sym_n, err_n, wr, swap, last;
  logic [CW-1:0] cnt_n;
  logic [IW-1:0] idx, mir;
  logic start_e, strb_e, wsel;
  // arm only after a genuine low sample, so a level held across reset release is ignored
  always_ff @(posedge clk_100MHz_i or posedge rst_i)
    if (rst_i) begin
      {start_s1, start_s2, start_d, start_arm} <= '0;
      {strb_s1, strb_s2, strb_d, strb_arm} <= '0;
      rdy <= '0;
    end else begin
      {start_s1, start_s2, start_d} <= {load_start_i, start_s1, start_s2};
      {strb_s1, strb_s2, strb_d} <= {coef_strobe_i, strb_s1, strb_s2};
      rdy <= {rdy[0], 1'b1};
      start_arm <= start_arm | (rdy[1] & ~start_s2);
      strb_arm <= strb_arm | (rdy[1] & ~strb_s2);
    end
  assign start_e = start_s2 & ~start_d & start_arm;
  assign strb_e = strb_s2 & ~strb_d & strb_arm;
  assign idx = coef_cnt_o[IW-1:0];
  assign mir = IW'(N_TAPS - 1) - idx;
  assign wsel = ~bank_sel_o;
  assign last = (coef_cnt_o + CW'(1)) == (sym ? HALF : FULL);
  assign loading_o = st != IDLE;
  always_comb begin
    st_n = st;
    cnt_n = coef_cnt_o;
    err_n = err_o;
    sym_n = sym;
    wr = 1'b0;
    swap = 1'b0;
    if (start_e) begin
      st_n = LOAD;
      cnt_n = '0;
      sym_n = sym_i;
      err_n = st != IDLE;
    end else begin
      if (strb_e && st == LOAD) begin
        wr = 1'b1;
        cnt_n = coef_cnt_o + CW'(1);
        st_n = last ? WAIT_SWAP : LOAD;
      end
      if (strb_e && st != LOAD) err_n = 1'b1;
      if (st == WAIT_SWAP && (!SWAP_ON_TICK || sample_tick_i)) begin
        swap = 1'b1;
        st_n = IDLE;
      end
    end
  end
  always_ff @(posedge clk_100MHz_i or posedge rst_i)
    if (rst_i) begin
      st <= IDLE;
      coef_cnt_o <= '0;
      err_o <= 1'b0;
      sym <= 1'b0;
      bank_sel_o <= 1'b0;
      load_done_o <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int t = 0; t < N_TAPS; t++)
          bank[b][t] <= '0;
    end else begin
      st <= st_n;
      coef_cnt_o <= cnt_n;
      err_o <= err_n;
      sym <= sym_n;
      bank_sel_o <= bank_sel_o ^ swap;
      load_done_o <= swap;
      if (wr) bank[wsel][idx] <= coef_i;
      if (wr && sym) bank[wsel][mir] <= coef_i;
    end
  for (genvar k = 0; k < N_TAPS; k++) begin : g_out
    assign coefs_o[k*COEF_W +: COEF_W] = bank[bank_sel_o][k];
  end
endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// tb_fir_coef_bank_ctrl: directed checks of loading, symmetric mode, swap timing, abort, errors and reset
module tb_fir_coef_bank_ctrl;
  localparam int N = 16;
  localparam int W = 12;
  logic clk = 0;
  logic rst = 1;
  logic load_start = 0, coef_strobe = 0, sym = 0, tick = 0;
  logic [W-1:0] coef = '0;
  logic [N*W-1:0] coefs;
  logic loading, load_done, bank_sel, err;
  logic [4:0] coef_cnt;
  int errors = 0, checks = 0;
  logic [W-1:0] tbl [N] = '{12'hF9D, 12'h041, 12'h088, 12'h021, 12'hF64, 12'hFAA, 12'h178, 12'h356,
                            12'h356, 12'h178, 12'hFAA, 12'hF64, 12'h021, 12'h088, 12'h041, 12'hF9D};
  logic [N*W-1:0] exp_a, exp_b;

  fir_coef_bank_ctrl #(.N_TAPS(N), .COEF_W(W), .SWAP_ON_TICK(1)) dut (
    .clk_100MHz_i(clk), .rst_i(rst), .load_start_i(load_start), .coef_i(coef),
    .coef_strobe_i(coef_strobe), .sym_i(sym), .sample_tick_i(tick), .coefs_o(coefs),
    .loading_o(loading), .load_done_o(load_done), .bank_sel_o(bank_sel),
    .coef_cnt_o(coef_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic s);
    sym = s;
    load_start = 1;
    repeat (4) @(negedge clk);
    load_start = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic strobe(input logic [W-1:0] v, input logic tk);
    coef = v;
    coef_strobe = 1;
    repeat (2) @(negedge clk);
    tick = tk;
    @(negedge clk);
    tick = 0;
    @(negedge clk);
    coef_strobe = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1;
    @(negedge clk);
    tick = 0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      exp_a[k*W +: W] = tbl[k];
      exp_b[k*W +: W] = W'(k + 'h100);
    end
    #1;
    check("rst_coefs", coefs, '0);
    check("rst_bank", bank_sel, 0);
    check("rst_cnt", coef_cnt, 0);
    check("rst_flags", {loading, load_done, err}, 3'b000);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);

    start(0);
    check("full_loading", loading, 1);
    for (int k = 0; k < N; k++) strobe(tbl[k], k == N - 1);
    check("full_cnt", coef_cnt, 16);
    check("full_noswap_same_cycle_tick", bank_sel, 0);
    check("full_shadow_hidden", coefs, '0);
    check("full_wait_loading", loading, 1);
    pulse_tick();
    check("full_bank", bank_sel, 1);
    check("full_done", load_done, 1);
    check("full_tap0", coefs[0 +: W], 12'hF9D);
    check("full_tap7", coefs[7*W +: W], 12'h356);
    check("full_tap15", coefs[15*W +: W], 12'hF9D);
    check("full_coefs", coefs, exp_a);
    @(negedge clk);
    check("full_done_one_cycle", load_done, 0);
    check("full_idle", loading, 0);

    start(1);
    for (int k = 0; k < N / 2; k++) strobe(tbl[k], 0);
    check("sym_cnt", coef_cnt, 8);
    repeat (100) @(negedge clk);
    check("hold_bank", bank_sel, 1);
    check("hold_loading", loading, 1);
    check("hold_coefs", coefs, exp_a);
    pulse_tick();
    check("sym_bank", bank_sel, 0);
    check("sym_done", load_done, 1);
    check("sym_coefs", coefs, exp_a);
    check("sym_err", err, 0);
    check("sym_cnt_hold", coef_cnt, 8);

    strobe(12'h7FF, 0);
    check("stray_err", err, 1);
    check("stray_bank", bank_sel, 0);
    check("stray_coefs", coefs, exp_a);
    check("stray_idle", loading, 0);

    start(0);
    check("abort_err_cleared", err, 0);
    for (int k = 0; k < 5; k++) strobe(W'(k + 1), 0);
    check("abort_cnt5", coef_cnt, 5);
    start(0);
    check("abort_cnt", coef_cnt, 0);
    check("abort_err", err, 1);
    check("abort_bank", bank_sel, 0);
    check("abort_coefs", coefs, exp_a);
    for (int k = 0; k < N; k++) strobe(W'(k + 'h100), 0);
    pulse_tick();
    check("reload_bank", bank_sel, 1);
    check("reload_coefs", coefs, exp_b);
    @(negedge clk);

    sym = 0;
    load_start = 1;
    coef_strobe = 1;
    coef = 12'h555;
    repeat (4) @(negedge clk);
    load_start = 0;
    coef_strobe = 0;
    repeat (4) @(negedge clk);
    check("both_cnt", coef_cnt, 0);
    check("both_loading", loading, 1);
    check("both_err", err, 0);

    for (int k = 0; k < 10; k++) strobe(W'(k + 'h200), 0);
    check("mid_cnt", coef_cnt, 10);
    coef_strobe = 1;
    #2 rst = 1;
    #1;
    check("mid_rst_coefs", coefs, '0);
    check("mid_rst_bank", bank_sel, 0);
    check("mid_rst_cnt", coef_cnt, 0);
    check("mid_rst_flags", {loading, load_done, err}, 3'b000);
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    check("rel_no_edge_err", err, 0);
    check("rel_cnt", coef_cnt, 0);
    check("rel_idle", loading, 0);
    check("rel_coefs", coefs, '0);
    coef_strobe = 0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
